anode_driver: RTL and testbench
===============================

ANODE_DRIVER -- requirements
Module: anode_driver

Interface
REQ-001 Parameter DIGIT_CYCLES, default 16: clock cycles per digit slot; legal range 4 or more.
REQ-002 Parameter BLANK_CYCLES, default 2: leading cycles of each slot with all anodes off; legal range 1 to DIGIT_CYCLES-1.
REQ-003 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 an3  output  1  active-low anode enable for digit 3 (leftmost), displays data[15:12].
REQ-006 an2  output  1  active-low anode enable for digit 2, displays data[11:8].
REQ-007 an1  output  1  active-low anode enable for digit 1, displays data[7:4].
REQ-008 an0  output  1  active-low anode enable for digit 0 (rightmost), displays data[3:0].
REQ-009 a, b, c, d, e, f, g  output  1 each  active-low segment drives; the vector order is {a,b,c,d,e,f,g}.
REQ-010 data  input  16  four display nibbles; may change at any time.

Function
REQ-011 Digits SHALL be scanned cyclically in the order an3, an2, an1, an0, an3, and so on; each slot lasts exactly DIGIT_CYCLES cycles.
REQ-012 Slot cycle k runs from 0 to DIGIT_CYCLES-1.
- For k below BLANK_CYCLES, all four anodes SHALL be 1.
- For k from BLANK_CYCLES to DIGIT_CYCLES-1, only the current digit's anode SHALL be 0.
REQ-013 At no time SHALL more than one anode be 0.
REQ-014 At slot cycle 0, the current digit's nibble SHALL be sampled from data.
- Segments SHALL show its decode from slot cycle 0 through the end of the slot.
- Segments SHALL change only while all anodes are 1 (ghost-free).
REQ-015 A data change mid-slot SHALL NOT affect the current slot; it SHALL appear at that digit's next slot.
REQ-016 All outputs SHALL be registered (glitch-free).
REQ-017 Decode table, {a..g}, 0 = lit:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000
- B=0111000 ("F" error glyph), C=0110001, D=1000010 ("d"), E=0110000
- F=1111111 (blank)
REQ-018 data=16'hBBBB is the system error word and SHALL render "FFFF".
REQ-019 The slot counter SHALL wrap from DIGIT_CYCLES-1 to 0 while advancing to the next digit; the digit index SHALL wrap from digit 0 to digit 3.

Reset
REQ-020 While reset=1 at a rising edge:
- an3..an0 SHALL be 1111.
- Segments SHALL be 1111111.
- Slot counter SHALL be 0 and digit index SHALL be 3.
REQ-021 Reset asserted mid-slot SHALL take effect at the next edge, discarding the partial slot.
REQ-022 The first rising edge with reset=0 SHALL be slot cycle 0 of digit 3.

Verification
REQ-023 Reset, then data=16'h1234, defaults.
- Anodes go low in order an3, an2, an1, an0, each for 14 cycles, with 2 all-high cycles before each.
- Segments per slot: 1001111, 0010010, 0000110, 1001100.
REQ-024 data=16'hBBBB.
- Every slot shows segments 0111000 ("F").
- The captured 4-digit display reads F,F,F,F.
REQ-025 Full table sweep: data=16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, one full scan each -> each digit matches REQ-017 exactly; F is blank (1111111).
REQ-026 Change data from 16'h1111 to 16'h2222 at slot cycle 5 of digit 3.
- Digit 3 keeps showing 1 until its slot ends.
- Digits 2, 1 and 0 show 2.
- Digit 3 shows 2 on the next scan.
REQ-027 Assert reset for 1 cycle at slot cycle 7 of digit 1.
- Next edge: all outputs are 1.
- Scan restarts at digit 3, slot cycle 0.
REQ-028 Check every cycle that at most one anode is 0, and that segments never change while any anode is 0.

Source files
------------

// File: rtl/anode_driver_if.sv
// Bus between the multiplexed 7-segment anode driver and its user.
//   data          : four display nibbles, {digit3, digit2, digit1, digit0}
//   an3..an0      : active-low anode enables, an3 is the leftmost digit
//   a..g          : active-low segment drives, vector order {a,b,c,d,e,f,g}
// The master modport is the driver side; the slave modport is the user side.
interface anode_driver_if;
    logic [15:0] data;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g;

    modport master (
        input  data,
        output an3, an2, an1, an0,
        output a, b, c, d, e, f, g
    );

    modport slave (
        output data,
        input  an3, an2, an1, an0,
        input  a, b, c, d, e, f, g
    );
endinterface

// File: rtl/anode_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digits are scanned 3,2,1,0 with DIGIT_CYCLES clocks per slot. The first
// BLANK_CYCLES clocks of every slot keep all anodes off; the segment pattern
// for the slot is loaded at slot cycle 0, so segments only ever change while
// the display is dark.
//   clk   : system clock, all state changes on its rising edge
//   reset : synchronous active-high reset
//   bus   : anode_driver_if.master (data in, anodes and segments out)
module anode_driver #(
    parameter int DIGIT_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    anode_driver_if.master        bus
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nibble;

    // Pattern {a..g}, 0 = lit. B is the "F" error glyph, F is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0111000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        case (digit_q)
            2'd3:    nibble = bus.data[15:12];
            2'd2:    nibble = bus.data[11:8];
            2'd1:    nibble = bus.data[7:4];
            default: nibble = bus.data[3:0];
        endcase
    end

    // Outputs registered below reflect the slot cycle held in cnt_q before
    // the edge, so the nibble is captured on the edge that begins the slot.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        an_d    = 4'hF;
        seg_d   = seg_q;

        if (cnt_q == CW'(0)) begin
            seg_d = seg_decode(nibble);
        end

        if (cnt_q >= CW'(BLANK_CYCLES)) begin
            an_d = 4'hF & ~(4'b0001 << digit_q);
        end

        // Digit index counts down 3,2,1,0 and wraps naturally to 3.
        if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
            cnt_d   = '0;
            digit_d = digit_q - 2'd1;
        end else begin
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            digit_q <= 2'd3;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.an3 = an_q[3];
    assign bus.an2 = an_q[2];
    assign bus.an1 = an_q[1];
    assign bus.an0 = an_q[0];
    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;

endmodule

// File: tb/tb_anode_driver.sv
module tb_anode_driver;

    localparam int DC = 16;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    anode_driver_if ifc ();

    anode_driver #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset release plus the current slot's pattern.
    int         m_t;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic [3:0] act_an;
    logic [6:0] act_seg;
    logic [6:0] prev_seg = 7'h7F;
    logic [6:0] seen [4];

    typedef struct {
        logic [15:0] data;
        logic [6:0]  s3, s2, s1, s0;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0111000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: inputs as driven before the edge, outputs sampled 1 time unit after.
    task automatic step();
        logic        r;
        logic [15:0] dv;
        int          k;
        int          dig;
        int          zeros;
        r  = reset;
        dv = ifc.data;
        @(posedge clk);
        #1;
        act_an  = {ifc.an3, ifc.an2, ifc.an1, ifc.an0};
        act_seg = {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e, ifc.f, ifc.g};
        if (r) begin
            m_t     = 0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            k   = m_t % DC;
            dig = 3 - ((m_t / DC) % 4);
            if (k == 0) exp_seg = ref_seg(dv[dig*4 +: 4]);
            exp_an = (k < BL) ? 4'hF : (4'hF & ~(4'b0001 << dig));
            m_t++;
        end
        chk("anodes", {12'h0, act_an}, {12'h0, exp_an});
        chk("segments", {9'h0, act_seg}, {9'h0, exp_seg});
        zeros = 0;
        for (int i = 0; i < 4; i++) if (act_an[i] !== 1'b1) zeros++;
        chk("at_most_one_anode", 16'(zeros <= 1), 16'd1);
        if (act_seg !== prev_seg) chk("ghost_free", {12'h0, act_an}, 16'h000F);
        prev_seg = act_seg;
        for (int i = 0; i < 4; i++) if (act_an[i] === 1'b0) seen[i] = act_seg;
    endtask

    task automatic do_reset(input logic [15:0] d);
        reset    = 1'b1;
        ifc.data = d;
        step();
        reset    = 1'b0;
        for (int i = 0; i < 4; i++) seen[i] = 'x;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        vecs[1] = '{16'hBBBB, 7'b0111000, 7'b0111000, 7'b0111000, 7'b0111000};
        vecs[2] = '{16'h0123, 7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
        vecs[3] = '{16'h4567, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
        vecs[4] = '{16'h89AB, 7'b0000000, 7'b0000100, 7'b0001000, 7'b0111000};
        vecs[5] = '{16'hCDEF, 7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111};

        ifc.data = 16'h0000;
        do_reset(16'h0000);
        chk("reset_anodes", {12'h0, act_an}, 16'h000F);
        chk("reset_segments", {9'h0, act_seg}, 16'h007F);

        // Table: one full scan per word, compare the pattern seen under each lit anode.
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].data);
            repeat (4 * DC) step();
            chk("tbl_digit3", {9'h0, seen[3]}, {9'h0, vecs[v].s3});
            chk("tbl_digit2", {9'h0, seen[2]}, {9'h0, vecs[v].s2});
            chk("tbl_digit1", {9'h0, seen[1]}, {9'h0, vecs[v].s1});
            chk("tbl_digit0", {9'h0, seen[0]}, {9'h0, vecs[v].s0});
        end

        // Data change at slot cycle 5 of digit 3 must not disturb that slot.
        do_reset(16'h1111);
        repeat (5) step();
        ifc.data = 16'h2222;
        repeat (4 * DC - 5) step();
        chk("midslot_d3_old", {9'h0, seen[3]}, 16'b1001111);
        chk("midslot_d2_new", {9'h0, seen[2]}, 16'b0010010);
        chk("midslot_d1_new", {9'h0, seen[1]}, 16'b0010010);
        chk("midslot_d0_new", {9'h0, seen[0]}, 16'b0010010);
        repeat (DC) step();
        chk("midslot_d3_next", {9'h0, seen[3]}, 16'b0010010);

        // One-cycle reset at slot cycle 7 of digit 1.
        do_reset(16'h5A3C);
        for (int n = 0; n < 8 * DC && m_t != 2 * DC + 7; n++) step();
        chk("reach_d1_k7", m_t[15:0], 16'(2 * DC + 7));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_anodes", {12'h0, act_an}, 16'h000F);
        chk("midreset_segments", {9'h0, act_seg}, 16'h007F);
        step();
        chk("restart_anodes", {12'h0, act_an}, 16'h000F);
        chk("restart_digit3_seg", {9'h0, act_seg}, 16'b0100100);
        repeat (BL) step();
        chk("restart_an3_low", {12'h0, act_an}, 16'b0111);

        // Randomized data changes and occasional resets against the model.
        do_reset(16'($urandom));
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) ifc.data = 16'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
